// File: rtl/kfn_topk_collector.sv
// Top-K furthest-neighbour collector: keeps the K largest candidate distances in sorted order
// and streams them out in descending order after the last candidate. Option macro: TOPK_SIGNED_EN.
module kfn_topk_collector #(
  parameter int psum_bw = 16,
  parameter int K       = 4,
  parameter int idx_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [psum_bw-1:0] in_psum,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out_dist,
  output logic [idx_bw-1:0]  out_idx,
  output logic [3:0]         out_rank,
  output logic               out_last
);

  // state | meaning
  // FILL  | accepting candidates, table kept sorted descending
  // DRAIN | presenting table entries rank 0..valid_count-1
  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t             state;
  logic [psum_bw-1:0] dist_q [K];
  logic [idx_bw-1:0]  idx_q  [K];
  logic [4:0]         valid_count;
  logic [idx_bw-1:0]  idx_cnt;
  logic [3:0]         rank_q;

  logic               accept;
  logic               ins_ok;
  logic [K-1:0]       stay;
  logic [psum_bw-1:0] dist_nxt [K];
  logic [idx_bw-1:0]  idx_nxt  [K];

  function automatic logic cand_gt(input logic [psum_bw-1:0] a, input logic [psum_bw-1:0] b);
`ifdef TOPK_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign out_last  = (state == DRAIN) && ({1'b0, rank_q} == valid_count - 5'd1);
  assign accept    = in_valid && in_ready && !clear;

  // An entry keeps its rank unless the candidate is strictly larger, so ties rank below.
  always_comb begin
    stay = '0;
    for (int i = 0; i < K; i++)
      stay[i] = (5'(i) < valid_count) && !cand_gt(in_psum, dist_q[i]);
  end

  // When even the lowest slot stays, the candidate falls off the end of a full table.
  assign ins_ok = !stay[K-1];

  always_comb begin
    for (int i = 0; i < K; i++) begin
      dist_nxt[i] = dist_q[i];
      idx_nxt[i]  = idx_q[i];
    end
    if (!stay[0]) begin
      dist_nxt[0] = in_psum;
      idx_nxt[0]  = idx_cnt;
    end
    for (int i = 1; i < K; i++) begin
      if (!stay[i]) begin
        if (stay[i-1]) begin
          dist_nxt[i] = in_psum;
          idx_nxt[i]  = idx_cnt;
        end else begin
          dist_nxt[i] = dist_q[i-1];
          idx_nxt[i]  = idx_q[i-1];
        end
      end
    end
  end

  always_comb begin
    out_dist = '0;
    out_idx  = '0;
    out_rank = '0;
    if (state == DRAIN) begin
      out_rank = rank_q;
      for (int i = 0; i < K; i++) begin
        if (rank_q == 4'(i)) begin
          out_dist = dist_q[i];
          out_idx  = idx_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FILL;
      valid_count <= '0;
      idx_cnt     <= '0;
      rank_q      <= '0;
      for (int i = 0; i < K; i++) begin
        dist_q[i] <= '0;
        idx_q[i]  <= '0;
      end
    end else if (clear) begin
      state       <= FILL;
      valid_count <= '0;
      idx_cnt     <= '0;
      rank_q      <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            idx_cnt <= idx_cnt + 1'b1;
            if (ins_ok) begin
              for (int i = 0; i < K; i++) begin
                dist_q[i] <= dist_nxt[i];
                idx_q[i]  <= idx_nxt[i];
              end
              if (valid_count != 5'(K))
                valid_count <= valid_count + 5'd1;
            end
            if (in_last)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              state       <= FILL;
              valid_count <= '0;
              idx_cnt     <= '0;
              rank_q      <= '0;
            end else begin
              rank_q <= rank_q + 4'd1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_kfn_topk_collector.sv
// Directed bench for kfn_topk_collector (K=4, psum_bw=16, idx_bw=8).
module tb_kfn_topk_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_psum = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_dist;
  logic [7:0]  out_idx;
  logic [3:0]  out_rank;
  logic        out_last;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [15:0] got_dist [16];
  logic [7:0]  got_idx  [16];
  logic [3:0]  got_rank [16];
  logic        got_last [16];
  int          got_n;
  int          stall_err;
  bit          timed_out;

  kfn_topk_collector #(.psum_bw(16), .K(4), .idx_bw(8)) dut (
    .clk(clk), .reset(reset), .in_psum(in_psum), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_dist(out_dist), .out_idx(out_idx), .out_rank(out_rank), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [15:0] v, input bit last);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b1;
    in_psum  = v;
    in_last  = last;
  endtask

  // Drains one query into got_*; with toggle, out_ready alternates starting with a stall.
  task automatic collect(input bit toggle);
    int cyc = 0;
    bit rdy = 1'b1;
    bit held = 1'b0;
    logic [15:0] hd = '0;
    logic [7:0]  hi = '0;
    logic [3:0]  hr = '0;
    got_n = 0; stall_err = 0; timed_out = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    forever begin
      if (!out_valid) break;
      if (cyc > 64 || got_n >= 16) begin timed_out = 1'b1; break; end
      if (held && (out_dist !== hd || out_idx !== hi || out_rank !== hr)) stall_err++;
      rdy = toggle ? ~rdy : 1'b1;
      out_ready = rdy;
      if (rdy) begin
        got_dist[got_n] = out_dist; got_idx[got_n] = out_idx;
        got_rank[got_n] = out_rank; got_last[got_n] = out_last;
        got_n++;
        held = 1'b0;
        if (out_last) begin @(negedge clk); break; end
      end else begin
        held = 1'b1; hd = out_dist; hi = out_idx; hr = out_rank;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    vec_cnt++;
    if ({in_ready, out_valid, out_dist, out_idx, out_rank, out_last} !== {1'b1, 1'b0, 16'h0, 8'h0, 4'h0, 1'b0}) begin
      err_cnt++;
      $display("FAIL reset_held rdy=%b vld=%b dist=%h idx=%h rank=%h last=%b, want rdy=1 others 0", in_ready, out_valid, out_dist, out_idx, out_rank, out_last);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_release in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic;
    logic [15:0] ed [4] = '{16'd9, 16'd9, 16'd7, 16'd5};
    logic [7:0]  ei [4] = '{8'd1, 8'd3, 8'd4, 8'd0};
    send(5, 0); send(9, 0); send(2, 0); send(9, 0); send(7, 1);
    collect(0);
    vec_cnt++;
    if (timed_out || got_n != 4) begin err_cnt++; $display("FAIL basic_count got %0d want 4 (timeout=%0b)", got_n, timed_out); end
    for (int j = 0; j < 4 && j < got_n; j++) begin
      vec_cnt++;
      if (got_dist[j] !== ed[j] || got_idx[j] !== ei[j] || got_rank[j] !== 4'(j) || got_last[j] !== (j == 3)) begin
        err_cnt++;
        $display("FAIL basic_rank%0d got (%0d,%0d,r%0d,l%b) want (%0d,%0d,r%0d,l%b)", j, got_dist[j], got_idx[j], got_rank[j], got_last[j], ed[j], ei[j], j, j == 3);
      end
    end
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_turnaround in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_short;
    send(3, 0); send(1, 1);
    collect(0);
    vec_cnt++;
    if (timed_out || got_n != 2) begin err_cnt++; $display("FAIL short_count got %0d want 2", got_n); end
    vec_cnt++;
    if (got_n == 2 && {got_dist[0], got_idx[0], got_last[0], got_dist[1], got_idx[1], got_rank[1], got_last[1]} !== {16'd3, 8'd0, 1'b0, 16'd1, 8'd1, 4'd1, 1'b1}) begin
      err_cnt++;
      $display("FAIL short_results got (%0d,%0d,l%b) (%0d,%0d,r%0d,l%b) want (3,0,l0) (1,1,r1,l1)", got_dist[0], got_idx[0], got_last[0], got_dist[1], got_idx[1], got_rank[1], got_last[1]);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] ed [4] = '{16'd9, 16'd9, 16'd7, 16'd5};
    logic [7:0]  ei [4] = '{8'd1, 8'd3, 8'd4, 8'd0};
    send(5, 0); send(9, 0); send(2, 0); send(9, 0); send(7, 1);
    collect(1);
    vec_cnt++;
    if (timed_out || got_n != 4) begin err_cnt++; $display("FAIL bp_count got %0d want 4", got_n); end
    vec_cnt++;
    if (stall_err != 0) begin err_cnt++; $display("FAIL bp_stable got %0d changes while stalled want 0", stall_err); end
    for (int j = 0; j < 4 && j < got_n; j++) begin
      vec_cnt++;
      if (got_dist[j] !== ed[j] || got_idx[j] !== ei[j] || got_rank[j] !== 4'(j)) begin
        err_cnt++;
        $display("FAIL bp_rank%0d got (%0d,%0d,r%0d) want (%0d,%0d,r%0d)", j, got_dist[j], got_idx[j], got_rank[j], ed[j], ei[j], j);
      end
    end
  endtask

  task automatic test_tie_full;
    send(8, 0); send(8, 0); send(8, 0); send(8, 0); send(8, 1);
    collect(0);
    vec_cnt++;
    if (timed_out || got_n != 4) begin err_cnt++; $display("FAIL tie_count got %0d want 4", got_n); end
    for (int j = 0; j < 4 && j < got_n; j++) begin
      vec_cnt++;
      if (got_dist[j] !== 16'd8 || got_idx[j] !== 8'(j)) begin
        err_cnt++;
        $display("FAIL tie_rank%0d got (%0d,%0d) want (8,%0d)", j, got_dist[j], got_idx[j], j);
      end
    end
  endtask

  task automatic test_signed;
    logic [15:0] ed0, ed1;
    logic [7:0]  ei0, ei1;
`ifdef TOPK_SIGNED_EN
    ed0 = 16'h0001; ei0 = 8'd1; ed1 = 16'hFFFF; ei1 = 8'd0;
`else
    ed0 = 16'hFFFF; ei0 = 8'd0; ed1 = 16'h0001; ei1 = 8'd1;
`endif
    send(16'hFFFF, 0); send(16'h0001, 1);
    collect(0);
    vec_cnt++;
    if (got_n != 2 || {got_dist[0], got_idx[0], got_dist[1], got_idx[1]} !== {ed0, ei0, ed1, ei1}) begin
      err_cnt++;
      $display("FAIL signedness got n=%0d (%h,%0d) (%h,%0d) want n=2 (%h,%0d) (%h,%0d)", got_n, got_dist[0], got_idx[0], got_dist[1], got_idx[1], ed0, ei0, ed1, ei1);
    end
  endtask

  task automatic test_clear;
    send(9, 0);
    @(negedge clk);
    in_valid = 1'b1; in_psum = 16'd50; in_last = 1'b0; clear = 1'b1;
    send(2, 1);
    collect(0);
    vec_cnt++;
    if (got_n != 1 || got_dist[0] !== 16'd2 || got_idx[0] !== 8'd0 || got_last[0] !== 1'b1) begin
      err_cnt++;
      $display("FAIL clear_fill got n=%0d (%0d,%0d,l%b) want n=1 (2,0,l1)", got_n, got_dist[0], got_idx[0], got_last[0]);
    end
    send(8, 0); send(6, 0); send(4, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b1 || out_dist !== 16'd8) begin err_cnt++; $display("FAIL clear_drain_start out_valid=%b dist=%0d want 1 8", out_valid, out_dist); end
    out_ready = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (out_rank !== 4'd1 || out_dist !== 16'd6) begin err_cnt++; $display("FAIL clear_second_cycle rank=%0d dist=%0d want 1 6", out_rank, out_dist); end
    out_ready = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_rank !== 4'd0) begin
      err_cnt++;
      $display("FAIL clear_after out_valid=%b in_ready=%b rank=%0d want 0 1 0", out_valid, in_ready, out_rank);
    end
    send(4, 1);
    collect(0);
    vec_cnt++;
    if (got_n != 1 || got_dist[0] !== 16'd4 || got_idx[0] !== 8'd0) begin
      err_cnt++;
      $display("FAIL clear_next_query got n=%0d (%0d,%0d) want n=1 (4,0)", got_n, got_dist[0], got_idx[0]);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] ed [4] = '{16'd255, 16'd255, 16'd254, 16'd253};
    logic [7:0]  ei [4] = '{8'd255, 8'd0, 8'd254, 8'd253};
    for (int i = 0; i < 256; i++) send(16'(i), 0);
    send(16'd255, 1);
    collect(0);
    vec_cnt++;
    if (timed_out || got_n != 4) begin err_cnt++; $display("FAIL wrap_count got %0d want 4", got_n); end
    for (int j = 0; j < 4 && j < got_n; j++) begin
      vec_cnt++;
      if (got_dist[j] !== ed[j] || got_idx[j] !== ei[j]) begin
        err_cnt++;
        $display("FAIL wrap_rank%0d got (%0d,%0d) want (%0d,%0d)", j, got_dist[j], got_idx[j], ed[j], ei[j]);
      end
    end
  endtask

  task automatic test_async_reset;
    send(3, 0); send(7, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b1 || out_dist !== 16'd7) begin err_cnt++; $display("FAIL areset_pre out_valid=%b dist=%0d want 1 7", out_valid, out_dist); end
    #2 reset = 1'b0;
    #1;
    vec_cnt++;
    if ({in_ready, out_valid, out_dist, out_idx, out_rank, out_last} !== {1'b1, 1'b0, 16'h0, 8'h0, 4'h0, 1'b0}) begin
      err_cnt++;
      $display("FAIL areset_now rdy=%b vld=%b dist=%h idx=%h rank=%h last=%b, want rdy=1 others 0", in_ready, out_valid, out_dist, out_idx, out_rank, out_last);
    end
    @(negedge clk);
    reset = 1'b1;
    send(6, 1);
    collect(0);
    vec_cnt++;
    if (got_n != 1 || got_dist[0] !== 16'd6 || got_idx[0] !== 8'd0) begin
      err_cnt++;
      $display("FAIL areset_after got n=%0d (%0d,%0d) want n=1 (6,0)", got_n, got_dist[0], got_idx[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_backpressure();
    test_tie_full();
    test_signed();
    test_clear();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
